// File: rtl/pow_req_arbiter.sv
// Round-robin arbiter sharing one iterative x^n engine between NREQ requesters.
// Build option: POW_REQ_ARBITER_ZERO_BYPASS_EN answers n==0 requests directly (res=1) without the engine.
module pow_req_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned XW   = 16,
    parameter int unsigned NW   = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*XW-1:0]        req_x,
    input  logic [NREQ*NW-1:0]        req_n,
    output logic [NREQ-1:0]           done,
    output logic [XW-1:0]             res,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      eng_start,
    output logic [XW-1:0]             eng_x,
    output logic [NW-1:0]             eng_n,
    input  logic                      eng_ready,
    input  logic [XW-1:0]             eng_out
);

    localparam int unsigned IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    idx;
    logic [IDW-1:0]    sel;
    logic [IDW-1:0]    gnt_nx;
    logic              any_req;
    logic              grant;
    logic              zero_n;
    logic [XW-1:0]     sel_x;
    logic [NW-1:0]     sel_n;
    logic [NREQ-1:0]   done_d;
    logic              busy_d;
    logic              start_d;
    logic [XW-1:0]     x_arr [NREQ];
    logic [NW-1:0]     n_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign x_arr[g] = req_x[g*XW +: XW];
        assign n_arr[g] = req_n[g*NW +: NW];
    end

    // First set request at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                sel     = idx;
            end
        end
    end

    assign sel_x = x_arr[sel];
    assign sel_n = n_arr[sel];

`ifdef POW_REQ_ARBITER_ZERO_BYPASS_EN
    assign zero_n = (sel_n == '0);
`else
    assign zero_n = 1'b0;
`endif

    // A zero-exponent bypass needs no engine, so it does not wait for eng_ready
    assign grant = any_req && (eng_ready || zero_n);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = zero_n ? RESP : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (eng_ready) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state
    always_comb begin
        gnt_nx  = gnt_id;
        done_d  = '0;
        busy_d  = (state_nx != IDLE);
        start_d = (state_nx == ISSUE);
        if (state == IDLE && grant) gnt_nx = sel;
        if (state_nx == RESP) done_d[gnt_nx] = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr    <= '0;
            gnt_id    <= '0;
            done      <= '0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
            eng_x     <= '0;
            eng_n     <= '0;
            res       <= '0;
        end else begin
            done      <= done_d;
            busy      <= busy_d;
            eng_start <= start_d;
            gnt_id    <= gnt_nx;
            if (state == IDLE && grant) begin
                rr_ptr <= (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
                if (zero_n) begin
                    res <= XW'(1);
                end else begin
                    eng_x <= sel_x;
                    eng_n <= sel_n;
                end
            end
            if (state == WAIT && eng_ready) res <= eng_out;
        end
    end

endmodule

// File: tb/tb_pow_req_arbiter.sv
// Bench for pow_req_arbiter: behavioural square-and-multiply engine, transaction-level
// reference model checked every cycle, directed cases with literal expectations, random traffic.
`timescale 1ns/1ps
module tb_pow_req_arbiter;
    localparam int NREQ = 4;
    localparam int XW   = 16;
    localparam int NW   = 8;
`ifdef POW_REQ_ARBITER_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk  = 1'b0;
    logic              nrst = 1'b0;
    logic [NREQ-1:0]   req;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*NW-1:0] req_n;
    logic [NREQ-1:0]   done;
    logic [XW-1:0]     res;
    logic              busy;
    logic [1:0]        gnt_id;
    logic              eng_start;
    logic [XW-1:0]     eng_x;
    logic [NW-1:0]     eng_n;
    logic              eng_ready;
    logic [XW-1:0]     eng_out;

    bit          rq [NREQ];
    logic [XW-1:0] ax [NREQ];
    logic [NW-1:0] an [NREQ];
    bit          dn [NREQ];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    for (genvar g = 0; g < NREQ; g++) begin : g_pk
        assign req[g] = rq[g];
        assign req_x[g*XW +: XW] = ax[g];
        assign req_n[g*NW +: NW] = an[g];
        assign dn[g] = done[g];
    end

    pow_req_arbiter #(.NREQ(NREQ), .XW(XW), .NW(NW)) dut (
        .clk(clk), .nrst(nrst), .req(req), .req_x(req_x), .req_n(req_n),
        .done(done), .res(res), .busy(busy), .gnt_id(gnt_id),
        .eng_start(eng_start), .eng_x(eng_x), .eng_n(eng_n),
        .eng_ready(eng_ready), .eng_out(eng_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine: one step per busy cycle, square on even exponent, multiply-and-decrement on odd
    logic [XW-1:0] e_acc, e_base;
    logic [NW-1:0] e_cnt;
    assign eng_ready = (e_cnt == '0);
    assign eng_out   = e_acc;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            e_acc <= '0; e_base <= '0; e_cnt <= '0;
        end else if (eng_start && eng_ready) begin
            e_acc <= 16'd1; e_base <= eng_x; e_cnt <= eng_n;
        end else if (e_cnt != '0) begin
            if (e_cnt[0]) begin
                e_acc <= 16'(e_acc * e_base); e_cnt <= e_cnt - 8'd1;
            end else begin
                e_base <= 16'(e_base * e_base); e_cnt <= e_cnt >> 1;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] powmod(input logic [15:0] x, input int n);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < n; i++) r = 16'(r * x);
        return r;
    endfunction

    // Engine busy cycles: floor(log2 n) squarings plus popcount(n) multiplies
    function automatic int steps(input int n);
        int s, v;
        s = 0; v = n;
        while (v > 1) begin v = v >> 1; s++; end
        return s + $countones(n);
    endfunction

    // Reference model: schedule of each transaction from its grant cycle
    int m_ptr, m_gnt, m_sel, m_grant_at, m_start_at, m_done_at, m_idle_at, m_s;
    logic [15:0] m_res, m_res_pend, m_ex;
    logic [7:0]  m_en;
    bit dn_seen [NREQ];
    int st_cnt = 0;
    logic [15:0] last_sx;
    logic [7:0]  last_sn;

    always @(negedge clk) begin
        if (!nrst) begin
            m_ptr = 0; m_gnt = 0; m_grant_at = -100; m_start_at = -100;
            m_done_at = -100; m_idle_at = 0; m_res = 0; m_ex = 0; m_en = 0;
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_gnt_id", gnt_id, 0);
            chk("rst_eng_start", eng_start, 0);
            chk("rst_eng_x", eng_x, 0);
            chk("rst_eng_n", eng_n, 0);
            chk("rst_res", res, 0);
            for (int i = 0; i < NREQ; i++) dn_seen[i] = 1'b0;
        end else begin
            if (cyc == m_done_at) m_res = m_res_pend;
            chk("done", done, (cyc == m_done_at) ? (1 << m_gnt) : 0);
            chk("busy", busy, (cyc > m_grant_at && cyc <= m_done_at) ? 1 : 0);
            chk("eng_start", eng_start, (cyc == m_start_at) ? 1 : 0);
            chk("gnt_id", gnt_id, m_gnt);
            chk("res", res, m_res);
            chk("eng_x", eng_x, m_ex);
            chk("eng_n", eng_n, m_en);
            if (eng_start) begin st_cnt++; last_sx = eng_x; last_sn = eng_n; end
            for (int i = 0; i < NREQ; i++) dn_seen[i] = dn[i];
            if (cyc >= m_idle_at) begin
                m_sel = -1;
                for (int k = 0; k < NREQ; k++)
                    if (m_sel < 0 && rq[(m_ptr + k) % NREQ]) m_sel = (m_ptr + k) % NREQ;
                if (m_sel >= 0 && (eng_ready || (BYP && an[m_sel] == 0))) begin
                    m_gnt = m_sel;
                    m_ptr = (m_sel + 1) % NREQ;
                    m_grant_at = cyc;
                    m_res_pend = powmod(ax[m_sel], int'(an[m_sel]));
                    if (BYP && an[m_sel] == 0) begin
                        m_done_at = cyc + 1;
                    end else begin
                        m_s = steps(int'(an[m_sel]));
                        m_start_at = cyc + 1;
                        m_done_at = cyc + 3 + m_s;
                        m_ex = ax[m_sel];
                        m_en = an[m_sel];
                    end
                    m_idle_at = m_done_at + 1;
                end
            end
        end
    end

    int got_n;
    int got_id [8];
    logic [15:0] got_res [8];

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        for (int i = 0; i < NREQ; i++) rq[i] = 1'b0;
        tick(2);
        nrst = 1'b1;
        tick(2);
    endtask

    // Single request with literal result, latency and engine-start count
    task automatic do_op(input int i, input logic [15:0] x, input logic [7:0] n,
                         input logic [15:0] er, input int elat, input int estarts, input string nm);
        int t0, d, s0;
        bit got;
        ax[i] = x; an[i] = n; rq[i] = 1'b1;
        t0 = cyc; s0 = st_cnt; got = 1'b0; d = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (dn[i]) begin got = 1'b1; d = cyc; end
        end
        chk({nm, "_seen"}, got, 1);
        if (got) begin
            chk({nm, "_lat"}, d - t0, elat);
            chk({nm, "_res"}, res, er);
            chk({nm, "_starts"}, st_cnt - s0, estarts);
        end
        @(posedge clk); #1;
        rq[i] = 1'b0;
    endtask

    // Gather done events in order; optionally release each finished requester
    task automatic collect(input int cnt, input bit drop);
        got_n = 0;
        for (int k = 0; k < 400 && got_n < cnt; k++) begin
            @(negedge clk);
            if (done != '0) begin
                for (int j = 0; j < NREQ; j++) if (dn[j]) got_id[got_n] = j;
                got_res[got_n] = res;
                got_n++;
                if (drop) begin @(posedge clk); #1; rq[got_id[got_n-1]] = 1'b0; end
            end
        end
        chk("collect_count", got_n, cnt);
    endtask

    initial begin
        int exp_ord [6];
        exp_ord = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NREQ; i++) begin rq[i] = 1'b0; ax[i] = '0; an[i] = '0; end
        tick(3);
        nrst = 1'b1;
        tick(2);

        do_op(0, 16'd3, 8'd4, 16'd81, 6, 1, "x3n4");
        chk("x3n4_eng_x", last_sx, 3);
        chk("x3n4_eng_n", last_sn, 4);
        @(negedge clk);
        chk("x3n4_busy_after", busy, 0);
        tick(1);

        do_reset();
        ax[0] = 16'd2; an[0] = 8'd5; ax[1] = 16'd5; an[1] = 8'd3;
        rq[0] = 1'b1; rq[1] = 1'b1;
        collect(2, 1'b1);
        chk("pair_first_id", got_id[0], 0);
        chk("pair_first_res", got_res[0], 32);
        chk("pair_second_id", got_id[1], 1);
        chk("pair_second_res", got_res[1], 125);
        tick(2);

        do_reset();
        for (int i = 0; i < NREQ; i++) begin ax[i] = 16'd2; an[i] = 8'd1; rq[i] = 1'b1; end
        collect(6, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) rq[i] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("rr_order", got_id[k], exp_ord[k]);
            chk("rr_res", got_res[k], 2);
        end
        tick(6);

        do_op(1, 16'd300, 8'd2, 16'd24464, 5, 1, "x300n2");
        tick(1);
        do_op(2, 16'hFFFF, 8'd255, 16'hFFFF, 18, 1, "xffffn255");
        tick(1);
        do_op(3, 16'd7, 8'd0, 16'd1, BYP ? 1 : 3, BYP ? 0 : 1, "x7n0");
        tick(1);

        // Dropping req after grant still returns the result
        ax[3] = 16'd4; an[3] = 8'd2; rq[3] = 1'b1;
        tick(2);
        rq[3] = 1'b0;
        collect(1, 1'b0);
        chk("drop_id", got_id[0], 3);
        chk("drop_res", got_res[0], 16);
        tick(2);

        // Reset while the engine is working
        do_reset();
        ax[0] = 16'd3; an[0] = 8'd200; rq[0] = 1'b1;
        tick(4);
        nrst = 1'b0; rq[0] = 1'b0;
        @(negedge clk);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", eng_start, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        tick(1);
        do_op(2, 16'd5, 8'd3, 16'd125, 6, 1, "after_rst");
        chk("after_rst_gnt", gnt_id, 2);
        tick(2);

        // Random traffic against the model
        repeat (3000) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i] && dn_seen[i]) begin
                    if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
                    else begin
                        ax[i] = 16'($urandom);
                        an[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
                    end
                end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
                    ax[i] = 16'($urandom);
                    an[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
                    rq[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) rq[i] = 1'b0;
        tick(60);
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
